// File: rtl/speaker_tone_gen.sv
// ---------------------------------------------------------------------------
// speaker_tone_gen
//
// Purpose:
//   Converts the level-type speaker requests from the obstacle-warning state
//   machine into a beeping square wave on the matching speaker pin. Each
//   channel has its own tone pitch. The burst/silence cadence is shared by
//   all channels, and only one speaker is driven at a time.
//
// Ports:
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  synchronous active-low reset (wins over ena)
//   ena      in   1  design enable; when low every register holds
//   spk_en   in   3  speaker requests (bit k = speaker k), lowest index wins
//   spk_drv  out  3  speaker drive pins, 000 or one-hot
//   active   out  1  high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module speaker_tone_gen #(
    parameter int CNT_W     = 16,
    parameter int TONE_DIV0 = 12500,
    parameter int TONE_DIV1 = 10000,
    parameter int TONE_DIV2 = 8333,
    parameter int BEEP_ON   = 50000,
    parameter int BEEP_OFF  = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] spk_en,
    output logic [2:0] spk_drv,
    output logic       active
);

    // Terminal counts, pre-reduced by one so every compare is a plain ==.
    localparam logic [CNT_W-1:0] TONE_MAX0 = CNT_W'(TONE_DIV0 - 1);
    localparam logic [CNT_W-1:0] TONE_MAX1 = CNT_W'(TONE_DIV1 - 1);
    localparam logic [CNT_W-1:0] TONE_MAX2 = CNT_W'(TONE_DIV2 - 1);
    localparam logic [CNT_W-1:0] ON_MAX    = CNT_W'(BEEP_ON - 1);
    localparam logic [CNT_W-1:0] OFF_MAX   = CNT_W'(BEEP_OFF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t           state_q,    state_d;
    logic [1:0]       ch_q,       ch_d;
    logic [CNT_W-1:0] tone_cnt_q, tone_cnt_d;
    logic [CNT_W-1:0] cad_cnt_q,  cad_cnt_d;
    logic             phase_q,    phase_d;
    logic [2:0]       spk_drv_q,  spk_drv_d;
    logic             active_q,   active_d;

    logic [1:0]       sel;
    logic             req;
    logic [CNT_W-1:0] tone_max;
    logic             do_restart;
    logic             go_idle;

    function automatic logic [2:0] onehot(input logic [1:0] k);
        return 3'b001 << k;
    endfunction

    // Fixed priority: lowest-index request wins.
    always_comb begin
        sel = 2'd0;
        if (spk_en[0])      sel = 2'd0;
        else if (spk_en[1]) sel = 2'd1;
        else if (spk_en[2]) sel = 2'd2;
    end

    assign req = |spk_en;

    always_comb begin
        tone_max = TONE_MAX2;
        case (ch_q)
            2'd0:    tone_max = TONE_MAX0;
            2'd1:    tone_max = TONE_MAX1;
            default: tone_max = TONE_MAX2;
        endcase
    end

    // Next-state logic. Restart and return-to-idle are common actions taken
    // from several states, so they are flagged here and applied once below.
    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        tone_cnt_d = tone_cnt_q;
        cad_cnt_d  = cad_cnt_q;
        phase_d    = phase_q;
        spk_drv_d  = spk_drv_q;
        do_restart = 1'b0;
        go_idle    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) do_restart = 1'b1;
                else     spk_drv_d  = 3'b000;
            end
            ST_ON: begin
                if (!req) begin
                    go_idle = 1'b1;
                end else if (sel != ch_q) begin
                    // New direction aborts the current burst at once.
                    do_restart = 1'b1;
                end else begin
                    if (tone_cnt_q == tone_max) begin
                        tone_cnt_d = '0;
                        phase_d    = ~phase_q;
                    end else begin
                        tone_cnt_d = tone_cnt_q + CNT_ONE;
                    end
                    if (cad_cnt_q == ON_MAX) begin
                        state_d   = ST_OFF;
                        cad_cnt_d = '0;
                        spk_drv_d = 3'b000;
                    end else begin
                        cad_cnt_d = cad_cnt_q + CNT_ONE;
                        // Pin follows the updated phase so the output edge
                        // lands exactly every TONE_DIV cycles.
                        spk_drv_d = phase_d ? onehot(ch_q) : 3'b000;
                    end
                end
            end
            ST_OFF: begin
                spk_drv_d = 3'b000;
                if (!req) begin
                    go_idle = 1'b1;
                end else if ((sel != ch_q) || (cad_cnt_q == OFF_MAX)) begin
                    // A new direction is not held back by the silence gap.
                    do_restart = 1'b1;
                end else begin
                    cad_cnt_d = cad_cnt_q + CNT_ONE;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (do_restart) begin
            state_d    = ST_ON;
            ch_d       = sel;
            tone_cnt_d = '0;
            cad_cnt_d  = '0;
            phase_d    = 1'b1;
            spk_drv_d  = onehot(sel);
        end
        if (go_idle) begin
            state_d    = ST_IDLE;
            tone_cnt_d = '0;
            cad_cnt_d  = '0;
            phase_d    = 1'b0;
            spk_drv_d  = 3'b000;
        end

        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ch_q       <= 2'd0;
            tone_cnt_q <= '0;
            cad_cnt_q  <= '0;
            phase_q    <= 1'b0;
            spk_drv_q  <= 3'b000;
            active_q   <= 1'b0;
        end else if (ena) begin
            state_q    <= state_d;
            ch_q       <= ch_d;
            tone_cnt_q <= tone_cnt_d;
            cad_cnt_q  <= cad_cnt_d;
            phase_q    <= phase_d;
            spk_drv_q  <= spk_drv_d;
            active_q   <= active_d;
        end
    end

    assign spk_drv = spk_drv_q;
    assign active  = active_q;

endmodule

// File: tb/tb_speaker_tone_gen.sv
module tb_speaker_tone_gen;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [2:0] spk_en;
    logic [2:0] spk_drv;
    logic       active;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected {spk_drv, active} and a tag, pushed when stimulus
    // is driven and popped when the following clock edge has produced output.
    logic [3:0] exp_q[$];
    string      tag_q[$];

    speaker_tone_gen #(
        .CNT_W    (4),
        .TONE_DIV0(2),
        .TONE_DIV1(3),
        .TONE_DIV2(4),
        .BEEP_ON  (8),
        .BEEP_OFF (4)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .spk_en (spk_en),
        .spk_drv(spk_drv),
        .active (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_out();
        logic [3:0] exp_v;
        logic [3:0] obs_v;
        string      tag;
        exp_v = exp_q.pop_front();
        tag   = tag_q.pop_front();
        obs_v = {spk_drv, active};
        checks++;
        $display("step %0d %s: spk_drv=%b active=%b (expect %b/%b)",
                 checks, tag, obs_v[3:1], obs_v[0], exp_v[3:1], exp_v[0]);
        assert (obs_v === exp_v) else begin
            errors++;
            $error("FAIL %s: spk_drv/active observed %b/%b expected %b/%b",
                   tag, obs_v[3:1], obs_v[0], exp_v[3:1], exp_v[0]);
        end
    endtask

    // One clock: drive inputs at the falling edge, expect outputs after the
    // next rising edge, sample 1 time unit later.
    task automatic step(input logic r, input logic e, input logic [2:0] en,
                        input logic [2:0] exp_drv, input logic exp_act,
                        input string tag);
        @(negedge clk);
        rst_n  = r;
        ena    = e;
        spk_en = en;
        exp_q.push_back({exp_drv, exp_act});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // Reference pattern for a channel with half-period div, ON=8, OFF=4:
    // n is the cycle index since the burst start (0-based).
    function automatic logic ref_pin(input int div, input int n);
        int p;
        p = n % 12;
        if (p >= 8) return 1'b0;
        return ((p / div) % 2) == 0;
    endfunction

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        spk_en = 3'b111;

        // 1. Reset with all requests high and enable high.
        step(1'b0, 1'b1, 3'b111, 3'b000, 1'b0, "reset_a");
        step(1'b0, 1'b1, 3'b111, 3'b000, 1'b0, "reset_b");
        step(1'b1, 1'b1, 3'b000, 3'b000, 1'b0, "reset_release");

        // 2. Steady channel 0 for two full cadence periods.
        for (int i = 0; i < 24; i++)
            step(1'b1, 1'b1, 3'b001, {2'b00, ref_pin(2, i)}, 1'b1, "steady_ch0");

        // 3. Mid-burst switch from channel 0 to channel 2.
        step(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, "rst3");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 3'b001, {2'b00, ref_pin(2, i)}, 1'b1, "pre_switch");
        for (int i = 0; i < 12; i++)
            step(1'b1, 1'b1, 3'b100, {ref_pin(4, i), 2'b00}, 1'b1, "switch_ch2");

        // 4. Priority (011 selects 0) then drop during the silence.
        step(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, "rst4");
        for (int i = 0; i < 10; i++)
            step(1'b1, 1'b1, 3'b011, {2'b00, ref_pin(2, i)}, 1'b1, "prio_ch0");
        step(1'b1, 1'b1, 3'b000, 3'b000, 1'b0, "drop_idle");
        step(1'b1, 1'b1, 3'b000, 3'b000, 1'b0, "stay_idle");

        // 5. Enable freeze after burst cycle 2 on channel 1.
        step(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, "rst5");
        for (int i = 0; i < 2; i++)
            step(1'b1, 1'b1, 3'b010, {1'b0, ref_pin(3, i), 1'b0}, 1'b1, "pre_freeze");
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 3'b010, 3'b010, 1'b1, "freeze");
        for (int i = 2; i < 7; i++)
            step(1'b1, 1'b1, 3'b010, {1'b0, ref_pin(3, i), 1'b0}, 1'b1, "resume");

        // 6. Reset while disabled, mid-burst, then restart on release.
        step(1'b0, 1'b1, 3'b000, 3'b000, 1'b0, "rst6");
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 3'b001, {2'b00, ref_pin(2, i)}, 1'b1, "pre_reset");
        step(1'b0, 1'b0, 3'b001, 3'b000, 1'b0, "reset_mid");
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b1, 3'b001, {2'b00, ref_pin(2, i)}, 1'b1, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
